// File: rtl/frac_reduce.sv
// +-----------------------------------------------------------------------------+
// | frac_reduce: reduces num/den by their GCD (subtractive Euclid + restoring   |
// | division, one step per clock).                              Revision: 1.0  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module frac_reduce #(
  parameter int LENGTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_num,
  input  logic [LENGTH-1:0] in_den,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_num,
  output logic [LENGTH-1:0] out_den,
  output logic [LENGTH-1:0] out_gcd
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIVN = 3'd2,
    S_DIVD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   a_q, a_d, b_q, b_d;
  logic [LENGTH-1:0]   n0_q, n0_d, d0_q, d0_d;
  logic [LENGTH-1:0]   gcd_q, gcd_d;
  logic [LENGTH:0]     rem_q, rem_d;
  logic [LENGTH-1:0]   dv_q, dv_d;
  logic [LENGTH-1:0]   quo_q, quo_d;
  logic [LENGTH-1:0]   qn_q, qn_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [LENGTH-1:0]   out_num_q, out_num_d;
  logic [LENGTH-1:0]   out_den_q, out_den_d;
  logic [LENGTH-1:0]   out_gcd_q, out_gcd_d;

  logic [LENGTH:0]     div_shift;
  logic                div_ge;
  logic [LENGTH:0]     div_rem;
  logic [LENGTH-1:0]   div_quo;
  logic [LENGTH-1:0]   gcd_exit;

  // One restoring-division step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    div_shift = {rem_q[LENGTH-1:0], dv_q[LENGTH-1]};
    div_ge    = (div_shift >= {1'b0, gcd_q});
    div_rem   = div_ge ? (div_shift - {1'b0, gcd_q}) : div_shift;
    div_quo   = {quo_q[LENGTH-2:0], div_ge};
    gcd_exit  = (a_q == '0) ? b_q : a_q;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    n0_d        = n0_q;
    d0_d        = d0_q;
    gcd_d       = gcd_q;
    rem_d       = rem_q;
    dv_d        = dv_q;
    quo_d       = quo_q;
    qn_d        = qn_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_num_d   = out_num_q;
    out_den_d   = out_den_q;
    out_gcd_d   = out_gcd_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_num;
          b_d     = in_den;
          n0_d    = in_num;
          d0_d    = in_den;
          state_d = S_GCD;
        end
      end
      S_GCD: begin
        // b==0 only occurs for a zero denominator; gcd(n,0)=n avoids an endless a-0 loop.
        if ((a_q == '0) || (b_q == '0)) begin
          gcd_d = gcd_exit;
          rem_d = '0;
          dv_d  = n0_q;
          quo_d = '0;
          qn_d  = '0;
          cnt_d = '0;
          state_d = (gcd_exit == '0) ? S_DONE : S_DIVN;
        end else if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
      S_DIVN: begin
        rem_d = div_rem;
        dv_d  = {dv_q[LENGTH-2:0], 1'b0};
        quo_d = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          qn_d    = div_quo;
          rem_d   = '0;
          dv_d    = d0_q;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIVD;
        end
      end
      S_DIVD: begin
        rem_d = div_rem;
        dv_d  = {dv_q[LENGTH-2:0], 1'b0};
        quo_d = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_num_d   = qn_q;
          out_den_d   = quo_q;
          out_gcd_d   = gcd_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      n0_q        <= '0;
      d0_q        <= '0;
      gcd_q       <= '0;
      rem_q       <= '0;
      dv_q        <= '0;
      quo_q       <= '0;
      qn_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
      out_den_q   <= '0;
      out_gcd_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      n0_q        <= n0_d;
      d0_q        <= d0_d;
      gcd_q       <= gcd_d;
      rem_q       <= rem_d;
      dv_q        <= dv_d;
      quo_q       <= quo_d;
      qn_q        <= qn_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_num_q   <= out_num_d;
      out_den_q   <= out_den_d;
      out_gcd_q   <= out_gcd_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_num   = out_num_q;
  assign out_den   = out_den_q;
  assign out_gcd   = out_gcd_q;

endmodule

`default_nettype wire
